// File: rtl/zigzag_reorder_if.sv
// Stream bundle for the zigzag reorder block: raster-order coefficients in,
// zigzag-ordered coefficients out, each side with its own valid/ready pair.
interface zigzag_reorder_if #(
  parameter int DATA_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [5:0]        out_idx;
  logic              out_last;

  // Producer/consumer side that drives coefficients in and drains them out.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last
  );

  // Reorder block side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output out_last
  );
endinterface

// File: rtl/zigzag_reorder.sv
// Ping-pong 8x8 block buffer: writes 64 coefficients in raster order into one
// bank while the other bank drains in JPEG zigzag order. Coefficient data is
// opaque and passed through untouched; bank contents are never reset.
module zigzag_reorder #(
  parameter int DATA_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  zigzag_reorder_if.slave s
);

  localparam logic [5:0] LAST_POS = 6'd63;

  // Zigzag position -> raster index (u*8+v), standard JPEG scan order.
  function automatic logic [5:0] zz_rom(input logic [5:0] pos);
    logic [5:0] r;
    r = 6'd0;
    case (pos)
      6'd0:  r = 6'd0;
      6'd1:  r = 6'd1;
      6'd2:  r = 6'd8;
      6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;
      6'd5:  r = 6'd2;
      6'd6:  r = 6'd3;
      6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;
      6'd9:  r = 6'd24;
      6'd10: r = 6'd32;
      6'd11: r = 6'd25;
      6'd12: r = 6'd18;
      6'd13: r = 6'd11;
      6'd14: r = 6'd4;
      6'd15: r = 6'd5;
      6'd16: r = 6'd12;
      6'd17: r = 6'd19;
      6'd18: r = 6'd26;
      6'd19: r = 6'd33;
      6'd20: r = 6'd40;
      6'd21: r = 6'd48;
      6'd22: r = 6'd41;
      6'd23: r = 6'd34;
      6'd24: r = 6'd27;
      6'd25: r = 6'd20;
      6'd26: r = 6'd13;
      6'd27: r = 6'd6;
      6'd28: r = 6'd7;
      6'd29: r = 6'd14;
      6'd30: r = 6'd21;
      6'd31: r = 6'd28;
      6'd32: r = 6'd35;
      6'd33: r = 6'd42;
      6'd34: r = 6'd49;
      6'd35: r = 6'd56;
      6'd36: r = 6'd57;
      6'd37: r = 6'd50;
      6'd38: r = 6'd43;
      6'd39: r = 6'd36;
      6'd40: r = 6'd29;
      6'd41: r = 6'd22;
      6'd42: r = 6'd15;
      6'd43: r = 6'd23;
      6'd44: r = 6'd30;
      6'd45: r = 6'd37;
      6'd46: r = 6'd44;
      6'd47: r = 6'd51;
      6'd48: r = 6'd58;
      6'd49: r = 6'd59;
      6'd50: r = 6'd52;
      6'd51: r = 6'd45;
      6'd52: r = 6'd38;
      6'd53: r = 6'd31;
      6'd54: r = 6'd39;
      6'd55: r = 6'd46;
      6'd56: r = 6'd53;
      6'd57: r = 6'd60;
      6'd58: r = 6'd61;
      6'd59: r = 6'd54;
      6'd60: r = 6'd47;
      6'd61: r = 6'd55;
      6'd62: r = 6'd62;
      6'd63: r = 6'd63;
    endcase
    return r;
  endfunction

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [5:0]        wr_cnt_q, wr_cnt_d;
  logic [5:0]        rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] bank0_q [64];
  logic [DATA_W-1:0] bank1_q [64];
  logic              wr_fire;
  logic              rd_fire;
  logic [5:0]        rd_idx;

  // Handshakes and read port, all combinational from registered state.
  always_comb begin
    s.in_ready  = ~full_q[wr_bank_q];
    s.out_valid = full_q[rd_bank_q];
    // restart discards this cycle's coefficient even if the handshake is up
    wr_fire     = s.in_valid & ~full_q[wr_bank_q] & ~restart;
    rd_fire     = full_q[rd_bank_q] & s.out_ready;
    rd_idx      = zz_rom(rd_cnt_q);
    s.out_idx   = rd_idx;
    s.out_data  = rd_bank_q ? bank1_q[rd_idx] : bank0_q[rd_idx];
    s.out_last  = full_q[rd_bank_q] & (rd_cnt_q == LAST_POS);
  end

  // Next-state for write/read counters, bank pointers and full flags.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    if (restart) begin
      wr_cnt_d = 6'd0;
    end else if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + 6'd1;
      if (wr_cnt_q == LAST_POS) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // A completing read never targets the bank a completing write fills,
    // since a full bank refuses writes; both updates can apply together.
    if (rd_fire) begin
      rd_cnt_d = rd_cnt_q + 6'd1;
      if (rd_cnt_q == LAST_POS) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= 6'd0;
      rd_cnt_q  <= 6'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Coefficient storage: raster-order writes into the active write bank.
  always_ff @(posedge clk) begin
    if (rst && wr_fire) begin
      if (wr_bank_q) begin
        bank1_q[wr_cnt_q] <= s.in_data;
      end else begin
        bank0_q[wr_cnt_q] <= s.in_data;
      end
    end
  end

endmodule

// File: tb/tb_zigzag_reorder.sv
// Bench for zigzag_reorder: scenario tasks drive the stream while a monitor
// process models the ping-pong buffer and checks every emitted coefficient.
module tb_zigzag_reorder;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic restart = 1'b0;

  zigzag_reorder_if #(.DATA_W(DW)) bus();

  zigzag_reorder #(.DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .s       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [5:0]    idx;
    logic          last;
  } exp_t;

  exp_t          sb[$];
  int            zz[64];
  logic [DW-1:0] mbuf[64];
  int            mcnt;
  int            n_out;
  int            n_last;
  int            checks;
  int            errors;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out_last got=%b want=0", bus.out_last);
    end
    checks++;
    if (bus.out_idx !== 6'd0) begin
      errors++; $display("FAIL reset_out_idx got=%0d want=0", bus.out_idx);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_block();
    int l0;
    bit ok;
    l0 = n_last;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 6'd0 || bus.out_data !== DW'(0)) begin
      errors++;
      $display("FAIL single_first_out got valid=%b idx=%0d data=%0d want valid=1 idx=0 data=0",
               bus.out_valid, bus.out_idx, bus.out_data);
    end
    drain(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_drain got timeout want drained sb=%0d", sb.size());
    end
    checks++;
    if (n_last - l0 !== 1) begin
      errors++; $display("FAIL single_last_count got=%0d want=1", n_last - l0);
    end
  endtask

  task automatic test_back_to_back();
    int o0, l0, drops;
    bit ok;
    o0 = n_out;
    l0 = n_last;
    drops = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 192; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i);
      if (bus.in_ready !== 1'b1) drops++;
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (drops !== 0) begin
      errors++; $display("FAIL b2b_in_ready_drops got=%0d want=0", drops);
    end
    drain(300, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL b2b_drain got timeout want drained sb=%0d", sb.size());
    end
    checks++;
    if (n_out - o0 !== 192) begin
      errors++; $display("FAIL b2b_out_count got=%0d want=192", n_out - o0);
    end
    checks++;
    if (n_last - l0 !== 3) begin
      errors++; $display("FAIL b2b_last_count got=%0d want=3", n_last - l0);
    end
  endtask

  task automatic test_stall();
    int drops;
    bit ok;
    drops = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i < 64) ? DW'(200 + i) : DW'(300 + i - 64);
      if (bus.in_ready !== 1'b1) drops++;
      tick();
    end
    checks++;
    if (drops !== 0) begin
      errors++; $display("FAIL stall_early_drop got=%0d want=0", drops);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready_after_128 got=%b want=0", bus.in_ready);
    end
    bus.in_data = DW'(4000);
    tick();
    tick();
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL stall_in_ready_held got=%b want=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(200) || bus.out_idx !== 6'd0) begin
      errors++;
      $display("FAIL stall_hold got valid=%b data=%0d idx=%0d want valid=1 data=200 idx=0",
               bus.out_valid, bus.out_data, bus.out_idx);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      tick();
      if (k == 63) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready_early got=%b want=0", bus.in_ready);
        end
      end
      if (k == 64) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++; $display("FAIL stall_in_ready_release got=%b want=1", bus.in_ready);
        end
      end
    end
    drain(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_drain got timeout want drained sb=%0d", sb.size());
    end
  endtask

  task automatic test_restart();
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(500 + i);
      tick();
    end
    restart      = 1'b1;
    bus.in_data  = DW'(777);
    tick();
    restart = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(100 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_data !== DW'(100) || bus.out_idx !== 6'd0) begin
      errors++;
      $display("FAIL restart_first got data=%0d idx=%0d want data=100 idx=0",
               bus.out_data, bus.out_idx);
    end
    tick();
    checks++;
    if (bus.out_data !== DW'(101) || bus.out_idx !== 6'd1) begin
      errors++;
      $display("FAIL restart_second got data=%0d idx=%0d want data=101 idx=1",
               bus.out_data, bus.out_idx);
    end
    drain(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL restart_drain got timeout want drained sb=%0d", sb.size());
    end
  endtask

  task automatic test_random();
    int accepted, cycles, o0;
    bit ok;
    accepted = 0;
    cycles   = 0;
    o0       = n_out;
    while (accepted < 640 && cycles < 20000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = DW'($urandom_range(0, 4095));
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_valid && bus.in_ready) accepted++;
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (accepted !== 640) begin
      errors++; $display("FAIL random_accepted got=%0d want=640", accepted);
    end
    drain(500, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL random_drain got timeout want drained sb=%0d", sb.size());
    end
    checks++;
    if (n_out - o0 !== 640) begin
      errors++; $display("FAIL random_out_count got=%0d want=640", n_out - o0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i < 64) ? DW'(700 + i) : DW'(800 + i - 64);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 74; k++) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_idx !== 6'd0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state got valid=%b ready=%b idx=%0d last=%b want 0 1 0 0",
               bus.out_valid, bus.in_ready, bus.out_idx, bus.out_last);
    end
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(600 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== DW'(600) || bus.out_idx !== 6'd0) begin
      errors++;
      $display("FAIL midreset_fresh got valid=%b data=%0d idx=%0d want valid=1 data=600 idx=0",
               bus.out_valid, bus.out_data, bus.out_idx);
    end
    drain(200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL midreset_drain got timeout want drained sb=%0d", sb.size());
    end
  endtask

  initial begin
    int n;
    // Zigzag order derived by walking the anti-diagonals u+v = s.
    n = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int u = (s < 7 ? s : 7); u >= (s > 7 ? s - 7 : 0); u--) begin
          zz[n] = u * 8 + (s - u);
          n = n + 1;
        end
      end else begin
        for (int u = (s > 7 ? s - 7 : 0); u <= (s < 7 ? s : 7); u++) begin
          zz[n] = u * 8 + (s - u);
          n = n + 1;
        end
      end
    end
    mcnt   = 0;
    n_out  = 0;
    n_last = 0;
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst) begin
            sb.delete();
            mcnt = 0;
          end else begin
            if (bus.out_valid && bus.out_ready) begin
              n_out++;
              if (bus.out_last) n_last++;
              checks++;
              if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got data=%0d idx=%0d want no output",
                         bus.out_data, bus.out_idx);
              end else begin
                e = sb.pop_front();
                if (bus.out_data !== e.d || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                  errors++;
                  $display("FAIL sb_output got data=%0d idx=%0d last=%b want data=%0d idx=%0d last=%b",
                           bus.out_data, bus.out_idx, bus.out_last, e.d, e.idx, e.last);
                end
              end
            end
            if (restart) begin
              mcnt = 0;
            end else if (bus.in_valid && bus.in_ready) begin
              mbuf[mcnt] = bus.in_data;
              mcnt = mcnt + 1;
              if (mcnt == 64) begin
                for (int k = 0; k < 64; k++) begin
                  sb.push_back('{d: mbuf[zz[k]], idx: 6'(zz[k]), last: (k == 63)});
                end
                mcnt = 0;
              end
            end
          end
        end
      end
    join_none

    test_reset();
    test_single_block();
    test_back_to_back();
    test_stall();
    test_restart();
    test_random();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zigzag_reorder.md
Name: zigzag_reorder

Overview:
- Downstream of the 8x8 coefficient stage driven by the (u,v) block counter.
- Accepts 64 coefficients per block in raster order. Index = u*8+v, with v incrementing fastest, matching the counter sweep.
- Re-emits each block in standard JPEG zigzag order for the entropy coder, over a valid/ready stream.
- Double-buffered (ping-pong), so one block can be written while the previous block drains.

Parameters:
- DATA_W, 12, width of one coefficient in bits; data is opaque and passed through unmodified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low; state clears on a rising edge where rst==0.
- restart  in  1  abandon the partially written block; write counter returns to 0.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  block can accept a coefficient this cycle.
- in_data  in  DATA_W  coefficient, raster order.
- out_valid  out  1  out_data holds a valid zigzag-ordered coefficient.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_data  out  DATA_W  coefficient at the current zigzag position.
- out_idx  out  6  raster index (u*8+v) of the current out_data.
- out_last  out  1  high with out_valid on zigzag position 63.

Behaviour:
- State:
  - banks 0/1, 64 x DATA_W each;
  - full[1:0];
  - wr_bank, rd_bank (1 bit each);
  - wr_cnt[5:0], rd_cnt[5:0].
- Reset (rst==0 at an edge): full=00, wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0. Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_idx=0. out_data is don't-care while out_valid=0.
- Bank contents are not cleared by reset.
- in_ready = ~full[wr_bank]. This is a combinational function of registered state and does not depend on in_valid.
- Write handshake, when in_valid & in_ready:
  - bank[wr_bank][wr_cnt] <= in_data;
  - wr_cnt increments.
- On the write with wr_cnt==63:
  - wr_cnt wraps to 0;
  - full[wr_bank] <= 1;
  - wr_bank toggles.
- restart (registered):
  - wr_cnt <= 0, and the current cycle's write is discarded even if the handshake is high;
  - full flags, the read side and wr_bank are untouched;
  - restart outranks the write handshake.
- out_valid = full[rd_bank].
- Read path, combinational from registered state:
  - out_idx = ZZ[rd_cnt];
  - out_data = bank[rd_bank][ZZ[rd_cnt]];
  - out_last = out_valid & (rd_cnt==63).
- Read handshake, when out_valid & out_ready:
  - rd_cnt increments;
  - at 63: rd_cnt wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- ZZ is the standard JPEG zigzag table, 64 entries, implemented as a constant case ROM.
  - First entries: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5.
  - Last entries: ...,47,55,62,63.
- Latency: the 64th input is accepted at edge N. out_valid is high from the cycle after edge N, with out_idx=0. Minimum fill-to-first-output is 1 cycle.
- Throughput: 1 coefficient/cycle on each side. Sustained back-to-back blocks have no bubbles when out_ready is held at 1.
- Simultaneous events:
  - Read-completion and write-completion in the same cycle both apply. They touch different full bits, or the same bit only if wr_bank==rd_bank. In that case the bank was read-complete and is being refilled, which cannot happen since in_ready=0 while it is full. This case needs no priority.
  - Both banks full: in_ready=0; the input stalls until the reader releases a bank.
- out_data and out_idx hold stable while out_valid & ~out_ready.
- Reset mid-operation: all buffered blocks and partial writes are lost; outputs return to reset values on the next cycle.

Test Plan:
- Reset, then 64 writes with in_data=raster index 0..63 and out_ready=1 -> out_data sequence 0,1,8,16,9,2,3,10,...,62,63; out_last only on the 64th output; out_idx==out_data each cycle.
- Three blocks back-to-back (data = 64*blk + idx), out_ready=1 -> in_ready never drops; 192 outputs in zigzag order per block; out_last every 64 outputs.
- out_ready=0 while writing two blocks -> in_ready falls after the 128th write. A 129th in_valid is not accepted. out_data holds 0 (block 0, idx 0). Raise out_ready -> in_ready returns 1 cycle after block 0's 64th read.
- Write 20 coefficients, pulse restart, then write 64 coefficients 100..163 -> first output is 100 and second is 101; the 20 restarted values never appear.
- Random in_valid/out_ready toggling over 10 blocks -> scoreboard matches zigzag permutation per block; no loss or duplication.
- Assert rst=0 mid-drain (block 1 of 2 partially read) -> next cycle out_valid=0, in_ready=1; a fresh block after reset emits correctly from zigzag position 0.
